// File: rtl/obi_load_reorder_buffer_if.sv
// Load-unit request/response and OBI A/R channel signals of the load reorder buffer.
// The master modport is the buffer itself (it masters the OBI bus); slave is its environment.
interface obi_load_reorder_buffer_if #(
    parameter int unsigned ID_WIDTH      = 4,
    parameter int unsigned ADDR_WIDTH    = 56,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned TRANS_ID_BITS = 3
);
    logic                       ld_req_valid_i;
    logic                       ld_req_ready_o;
    logic [ADDR_WIDTH-1:0]      ld_req_addr_i;
    logic [DATA_WIDTH/8-1:0]    ld_req_be_i;
    logic [TRANS_ID_BITS-1:0]   ld_req_tid_i;
    logic                       obi_req_o;
    logic                       obi_gnt_i;
    logic [ADDR_WIDTH-1:0]      obi_addr_o;
    logic [DATA_WIDTH/8-1:0]    obi_be_o;
    logic [ID_WIDTH-1:0]        obi_aid_o;
    logic                       obi_rvalid_i;
    logic                       obi_rready_o;
    logic [ID_WIDTH-1:0]        obi_rid_i;
    logic [DATA_WIDTH-1:0]      obi_rdata_i;
    logic                       obi_err_i;
    logic                       ld_rsp_valid_o;
    logic                       ld_rsp_ready_i;
    logic [DATA_WIDTH-1:0]      ld_rsp_data_o;
    logic                       ld_rsp_err_o;
    logic [TRANS_ID_BITS-1:0]   ld_rsp_tid_o;

    modport master (
        input  ld_req_valid_i, ld_req_addr_i, ld_req_be_i, ld_req_tid_i,
        output ld_req_ready_o,
        output obi_req_o, obi_addr_o, obi_be_o, obi_aid_o,
        input  obi_gnt_i,
        input  obi_rvalid_i, obi_rid_i, obi_rdata_i, obi_err_i,
        output obi_rready_o,
        output ld_rsp_valid_o, ld_rsp_data_o, ld_rsp_err_o, ld_rsp_tid_o,
        input  ld_rsp_ready_i
    );

    modport slave (
        output ld_req_valid_i, ld_req_addr_i, ld_req_be_i, ld_req_tid_i,
        input  ld_req_ready_o,
        input  obi_req_o, obi_addr_o, obi_be_o, obi_aid_o,
        output obi_gnt_i,
        output obi_rvalid_i, obi_rid_i, obi_rdata_i, obi_err_i,
        input  obi_rready_o,
        input  ld_rsp_valid_o, ld_rsp_data_o, ld_rsp_err_o, ld_rsp_tid_o,
        output ld_rsp_ready_i
    );
endinterface

// File: rtl/obi_load_reorder_buffer.sv
// OBI load reorder buffer: issues up to NR_ENTRIES reads tagged with their slot index,
// absorbs R-channel beats in any order and returns them to the load unit in issue order.
module obi_load_reorder_buffer #(
    parameter int unsigned NR_ENTRIES    = 4,
    parameter int unsigned ID_WIDTH      = 4,
    parameter int unsigned ADDR_WIDTH    = 56,
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    obi_load_reorder_buffer_if.master bus
);
    localparam int unsigned PTR_W = $clog2(NR_ENTRIES);
    localparam int unsigned CNT_W = $clog2(NR_ENTRIES + 1);
    localparam int unsigned BE_W  = DATA_WIDTH / 8;

    typedef enum logic {IDLE, REQ} state_e;
    state_e state_q, state_d;

    logic [NR_ENTRIES-1:0]    alloc_q, done_q, squash_q, err_q;
    logic [TRANS_ID_BITS-1:0] tid_q  [NR_ENTRIES];
    logic [DATA_WIDTH-1:0]    data_q [NR_ENTRIES];
    logic [PTR_W-1:0]         head_q, tail_q, aid_q, rid_idx;
    logic [CNT_W-1:0]         cnt_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [BE_W-1:0]          be_q;

    logic full, req_ready, accept, obi_req, rid_hit, head_done, rsp_valid, pop;

    assign full      = (cnt_q == CNT_W'(NR_ENTRIES));
    assign rid_idx   = bus.obi_rid_i[PTR_W-1:0];
    // Beats whose id is out of range or names a free slot are dropped.
    assign rid_hit   = bus.obi_rvalid_i && (32'(bus.obi_rid_i) < 32'(NR_ENTRIES)) && alloc_q[rid_idx];
    assign head_done = alloc_q[head_q] && done_q[head_q];
    assign rsp_valid = !rst_i && !flush_i && head_done && !squash_q[head_q];
    // Squashed head entries retire silently once their beat has arrived.
    assign pop       = !rst_i && head_done && (squash_q[head_q] || (rsp_valid && bus.ld_rsp_ready_i));

    // A-phase state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A-phase next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        obi_req   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !rst_i && !full && !flush_i && !(|squash_q);
                accept    = req_ready && bus.ld_req_valid_i;
                if (accept) state_d = REQ;
            end
            REQ: begin
                obi_req = !rst_i;
                if (bus.obi_gnt_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold address, byte enables and aid stable from acceptance until grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            be_q   <= '0;
            aid_q  <= '0;
        end else if (accept) begin
            addr_q <= bus.ld_req_addr_i;
            be_q   <= bus.ld_req_be_i;
            aid_q  <= tail_q;
        end
    end

    // Slot storage, pointers and occupancy; later assignments win per slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alloc_q  <= '0;
            done_q   <= '0;
            squash_q <= '0;
            err_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                tid_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (flush_i) squash_q <= squash_q | alloc_q;
            if (rid_hit) begin
                data_q[rid_idx] <= bus.obi_rdata_i;
                err_q[rid_idx]  <= bus.obi_err_i;
                done_q[rid_idx] <= 1'b1;
            end
            if (pop) begin
                alloc_q[head_q]  <= 1'b0;
                done_q[head_q]   <= 1'b0;
                squash_q[head_q] <= 1'b0;
                head_q           <= head_q + PTR_W'(1);
            end
            if (accept) begin
                alloc_q[tail_q]  <= 1'b1;
                done_q[tail_q]   <= 1'b0;
                squash_q[tail_q] <= 1'b0;
                tid_q[tail_q]    <= bus.ld_req_tid_i;
                tail_q           <= tail_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    assign bus.ld_req_ready_o = req_ready;
    assign bus.obi_req_o      = obi_req;
    assign bus.obi_addr_o     = rst_i ? '0 : addr_q;
    assign bus.obi_be_o       = rst_i ? '0 : be_q;
    assign bus.obi_aid_o      = rst_i ? '0 : ID_WIDTH'(aid_q);
    assign bus.obi_rready_o   = !rst_i;
    assign bus.ld_rsp_valid_o = rsp_valid;
    assign bus.ld_rsp_data_o  = rst_i ? '0 : data_q[head_q];
    assign bus.ld_rsp_err_o   = rst_i ? 1'b0 : err_q[head_q];
    assign bus.ld_rsp_tid_o   = rst_i ? '0 : tid_q[head_q];

    // A response must target a slot that is currently allocated.
    a_rid_alloc: assert property (@(posedge clk_i) disable iff (rst_i)
        bus.obi_rvalid_i |-> ((32'(bus.obi_rid_i) < 32'(NR_ENTRIES)) && alloc_q[rid_idx]));
endmodule

// File: tb/tb_obi_load_reorder_buffer.sv
// Bench for obi_load_reorder_buffer: directed scenarios plus random traffic, all
// checked every cycle against an in-order queue model of outstanding loads.
module tb_obi_load_reorder_buffer;
    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 4;
    localparam int unsigned AW  = 56;
    localparam int unsigned DW  = 64;
    localparam int unsigned TW  = 3;
    localparam int unsigned BW  = DW / 8;

    typedef struct {
        int unsigned     aid;
        logic [TW-1:0]   tid;
        bit              done;
        logic [DW-1:0]   data;
        bit              err;
        bit              sq;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    obi_load_reorder_buffer_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                                 .TRANS_ID_BITS(TW)) bus ();

    obi_load_reorder_buffer #(.NR_ENTRIES(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW),
                              .DATA_WIDTH(DW), .TRANS_ID_BITS(TW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: loads in issue order plus the one A-phase awaiting grant.
    ent_t          q[$];
    int unsigned   next_aid;
    bit            a_pend;
    logic [AW-1:0] a_addr;
    logic [BW-1:0] a_be;
    int unsigned   a_aid;

    int unsigned n_checks;
    int unsigned n_errors;

    logic          s_ready, s_req, s_valid, s_err;
    logic [TW-1:0] s_tid;
    logic [DW-1:0] s_data;
    logic [IDW-1:0] s_aid;
    logic [AW-1:0] s_addr;
    bit            seen_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after negedge, compare against the model, advance the model at posedge.
    task automatic step(input bit r, input bit f, input bit v, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [TW-1:0] t, input bit g,
                        input bit rv, input logic [IDW-1:0] rid, input logic [DW-1:0] rd,
                        input bit re, input bit rr);
        bit   e_ready, e_req, e_valid, any_sq, pop;
        ent_t ne;
        @(negedge clk);
        rst = r;
        flush = f;
        bus.ld_req_valid_i = v;
        bus.ld_req_addr_i  = a;
        bus.ld_req_be_i    = be;
        bus.ld_req_tid_i   = t;
        bus.obi_gnt_i      = g;
        bus.obi_rvalid_i   = rv;
        bus.obi_rid_i      = rid;
        bus.obi_rdata_i    = rd;
        bus.obi_err_i      = re;
        bus.ld_rsp_ready_i = rr;
        #1;
        any_sq = 0;
        foreach (q[i]) if (q[i].sq) any_sq = 1;
        e_ready = !r && !a_pend && (q.size() < N) && !f && !any_sq;
        e_req   = !r && a_pend;
        e_valid = !r && !f && (q.size() > 0) && q[0].done && !q[0].sq;
        s_ready = bus.ld_req_ready_o;
        s_req   = bus.obi_req_o;
        s_valid = bus.ld_rsp_valid_o;
        s_err   = bus.ld_rsp_err_o;
        s_tid   = bus.ld_rsp_tid_o;
        s_data  = bus.ld_rsp_data_o;
        s_aid   = bus.obi_aid_o;
        s_addr  = bus.obi_addr_o;
        seen_valid |= (s_valid === 1'b1);
        check("ld_req_ready", s_ready, e_ready);
        check("obi_req", s_req, e_req);
        check("obi_rready", bus.obi_rready_o, !r);
        check("ld_rsp_valid", s_valid, e_valid);
        if (e_req) begin
            check("obi_addr", s_addr, a_addr);
            check("obi_be", bus.obi_be_o, a_be);
            check("obi_aid", s_aid, a_aid);
        end
        if (e_valid) begin
            check("rsp_data", s_data, q[0].data);
            check("rsp_tid", s_tid, q[0].tid);
            check("rsp_err", s_err, q[0].err);
        end
        if (r) begin
            check("rst_rsp_data", s_data, 0);
            check("rst_obi_addr", s_addr, 0);
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            next_aid = 0;
            a_pend = 0;
        end else begin
            pop = (q.size() > 0) && q[0].done && (q[0].sq || (e_valid && rr));
            if (f) foreach (q[i]) q[i].sq = 1;
            if (rv) foreach (q[i]) if (q[i].aid == 32'(rid)) begin
                q[i].done = 1;
                q[i].data = rd;
                q[i].err  = re;
            end
            if (pop) void'(q.pop_front());
            if (a_pend && g) a_pend = 0;
            if (v && e_ready) begin
                ne.aid = next_aid; ne.tid = t; ne.done = 0; ne.data = '0; ne.err = 0; ne.sq = 0;
                q.push_back(ne);
                a_pend = 1; a_addr = a; a_be = be; a_aid = next_aid;
                next_aid = (next_aid + 1) % N;
            end
        end
    endtask

    // A granted load that has not yet been answered, or -1 if none.
    function automatic int pick_rid();
        int unsigned c[$];
        foreach (q[i]) if (!q[i].done && !(a_pend && q[i].aid == a_aid)) c.push_back(q[i].aid);
        if (c.size() == 0) return -1;
        return int'(c[$urandom_range(0, c.size() - 1)]);
    endfunction

    task automatic idle(input bit rr);
        step(0, 0, 0, '0, '0, '0, 0, 0, '0, '0, 0, rr);
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [TW-1:0] t);
        step(0, 0, 1, a, '1, t, 0, 0, '0, '0, 0, 0);
        step(0, 0, 0, '0, '0, '0, 1, 0, '0, '0, 0, 0);
    endtask

    task automatic respond(input int unsigned rid, input logic [DW-1:0] d, input bit e, input bit rr);
        step(0, 0, 0, '0, '0, '0, 0, 1, IDW'(rid), d, e, rr);
    endtask

    // Grant, answer and consume everything outstanding within a cycle budget.
    task automatic drain(input int unsigned budget);
        int r;
        for (int unsigned c = 0; c < budget && q.size() > 0; c++) begin
            r = pick_rid();
            step(0, 0, 0, '0, '0, '0, 1, r >= 0, IDW'(r >= 0 ? r : 0),
                 {$urandom(), $urandom()}, 0, 1);
        end
        check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int r;
        n_checks = 0; n_errors = 0; next_aid = 0; a_pend = 0; seen_valid = 0;
        a_addr = '0; a_be = '0; a_aid = 0;

        step(1, 0, 0, '0, '0, '0, 0, 0, '0, '0, 0, 0);
        step(1, 0, 1, '1, '1, '1, 1, 0, '0, '0, 0, 1);
        check("reset_ready", s_ready, 0);
        check("reset_req", s_req, 0);
        idle(1);
        check("post_reset_ready", s_ready, 1);

        // Single load
        issue(AW'(64'h8000_0010), 3'd5);
        check("single_req", s_req, 1);
        check("single_aid", s_aid, 0);
        check("single_addr", s_addr, 64'h8000_0010);
        idle(1);
        respond(0, 64'hDEAD_BEEF, 0, 1);
        check("single_same_cycle", s_valid, 0);
        idle(1);
        check("single_valid", s_valid, 1);
        check("single_data", s_data, 64'hDEAD_BEEF);
        check("single_tid", s_tid, 5);
        check("single_err", s_err, 0);

        // Out-of-order return, in-order delivery
        base = next_aid;
        issue(AW'(64'h100), 3'd1);
        issue(AW'(64'h108), 3'd2);
        issue(AW'(64'h110), 3'd3);
        respond((base + 2) % N, 64'h33, 0, 1);
        check("ooo_hold_a", s_valid, 0);
        respond(base % N, 64'h11, 0, 1);
        check("ooo_hold_b", s_valid, 0);
        respond((base + 1) % N, 64'h22, 0, 1);
        check("ooo_first_valid", s_valid, 1);
        check("ooo_first_tid", s_tid, 1);
        idle(1);
        check("ooo_second_tid", s_tid, 2);
        check("ooo_second_data", s_data, 64'h22);
        idle(1);
        check("ooo_third_tid", s_tid, 3);
        idle(1);
        check("ooo_empty", s_valid, 0);

        // Full and wrap-around
        base = next_aid;
        for (int unsigned i = 0; i < N; i++) issue(AW'(64'h200 + 8 * i), TW'(4 + i));
        idle(0);
        check("full_ready", s_ready, 0);
        respond(base, 64'h44, 0, 0);
        idle(1);
        check("full_pop_tid", s_tid, 4);
        step(0, 0, 1, AW'(64'h300), '1, 3'd0, 0, 0, '0, '0, 0, 0);
        check("wrap_ready", s_ready, 1);
        step(0, 0, 0, '0, '0, '0, 1, 0, '0, '0, 0, 0);
        check("wrap_aid", s_aid, base);
        drain(40);

        // Grant stall
        base = next_aid;
        step(0, 0, 1, AW'(56'h12_3456_789A_BCDE), 8'h0F, 3'd6, 0, 0, '0, '0, 0, 0);
        for (int unsigned i = 0; i < 5; i++) begin
            step(0, 0, 1, AW'(64'h400), '1, 3'd1, 0, 0, '0, '0, 0, 1);
            check("stall_req", s_req, 1);
            check("stall_addr", s_addr, 56'h12_3456_789A_BCDE);
            check("stall_aid", s_aid, base);
            check("stall_ready", s_ready, 0);
        end
        step(0, 0, 0, '0, '0, '0, 1, 0, '0, '0, 0, 0);
        drain(40);

        // Flush with two granted loads and one still requesting
        issue(AW'(64'h500), 3'd1);
        issue(AW'(64'h508), 3'd2);
        step(0, 0, 1, AW'(64'h510), '1, 3'd3, 0, 0, '0, '0, 0, 0);
        seen_valid = 0;
        step(0, 1, 1, AW'(64'h518), '1, 3'd4, 0, 0, '0, '0, 0, 1);
        check("flush_req_held", s_req, 1);
        step(0, 0, 1, AW'(64'h518), '1, 3'd4, 1, 0, '0, '0, 0, 1);
        check("flush_blocked", s_ready, 0);
        drain(40);
        check("flush_no_rsp", seen_valid, 0);
        idle(1);
        check("flush_ready_back", s_ready, 1);

        // Bus error
        base = next_aid;
        issue(AW'(64'h600), 3'd7);
        idle(1);
        respond(base, 64'hBAD, 1, 1);
        idle(1);
        check("err_valid", s_valid, 1);
        check("err_flag", s_err, 1);

        // Reset while requesting
        step(0, 0, 1, AW'(64'h700), '1, 3'd2, 0, 0, '0, '0, 0, 0);
        step(1, 0, 0, '0, '0, '0, 0, 0, '0, '0, 0, 0);
        check("rst_mid_req", s_req, 0);
        idle(1);
        check("after_rst_req", s_req, 0);
        check("after_rst_valid", s_valid, 0);
        check("after_rst_ready", s_ready, 1);

        // Random traffic
        for (int unsigned c = 0; c < 3000; c++) begin
            r = pick_rid();
            step(0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                 AW'({$urandom(), $urandom()}), BW'($urandom()), TW'($urandom()),
                 $urandom_range(0, 1) == 1, (r >= 0) && ($urandom_range(0, 2) == 0),
                 IDW'(r >= 0 ? r : 0), {$urandom(), $urandom()},
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end
        drain(60);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
